seg7_scan_decoder: RTL and testbench

//  Inverse of the segment encoder. Snoops a multiplexed, active-low 7-segment bus
//  (segment lines plus one-hot digit select) and recovers the hex value shown on each digit.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_inv_lut.sv | 18 +
 rtl/seg7_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment readback monitor: the active-low
// segment patterns for every hex digit, the decode table built from them,
// and a helper that turns a segment pattern back into its hex value.
package seg7_pkg;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0011000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   localparam logic [6:0] SEG_TABLE [16] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
      SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
   };

   // Reverse lookup: the table index of a matching pattern is the hex value.
   // Anything not in the table (blank included) comes back as 0 with legal low.
   function automatic logic [3:0] seg7_to_hex(input logic [6:0] seg, output logic legal);
      logic [3:0] hex;
      hex   = 4'h0;
      legal = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_TABLE[i]) begin
            hex   = 4'(i);
            legal = 1'b1;
         end
      end
      return hex;
   endfunction

endpackage

// File: rtl/seg7_inv_lut.sv
// Purely combinational inverse segment lookup: active-low segment pattern in,
// hex value plus a legal flag out. No clock, no state.
module seg7_inv_lut
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic       legal,
   output logic [3:0] hex
);

   // Decode the pattern through the shared table; illegal patterns give
   // legal=0 and a don't-care value of zero.
   always_comb begin
      legal = 1'b0;
      hex   = seg7_to_hex(seg, legal);
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed active-low 7-segment bus. Samples the
// segment and digit-select lines, waits until they have been steady long
// enough, then records the hex value shown on the selected digit. Also
// reports when a full scan of all digits has been seen and when the bus
// has gone quiet for too long.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              iSEG,
   input  logic [NUM_DIGITS-1:0]   iDIG_SEL,
   output logic [4*NUM_DIGITS-1:0] oDIGITS,
   output logic [NUM_DIGITS-1:0]   oVALID,
   output logic [NUM_DIGITS-1:0]   oERR,
   output logic                    oFRAME,
   output logic                    oSTALE
);

   localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
   localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

   logic [6:0]            s1Seg;
   logic [6:0]            s2Seg;
   logic [NUM_DIGITS-1:0] s1Sel;
   logic [NUM_DIGITS-1:0] s2Sel;
   logic [STAB_W-1:0]     stabCnt;
   logic [STAB_W-1:0]     stabNext;
   logic                  captured;
   logic                  sameSample;
   logic                  fire;
   logic                  capValid;
   logic [6:0]            capSeg;
   logic [NUM_DIGITS-1:0] capSel;
   logic                  lutLegal;
   logic [3:0]            lutHex;
   logic [NUM_DIGITS-1:0] seen;
   logic [NUM_DIGITS-1:0] seenNext;
   logic [TMO_W-1:0]      tmoCnt;

   // Work out whether the bus held still this cycle, what the run-length
   // counter becomes, and whether this is the one moment in the dwell where
   // the value should be captured. Only a single selected digit can capture;
   // zero or multi-hot select just keeps counting without ever firing.
   always_comb begin
      sameSample = (s1Seg == s2Seg) && (s1Sel == s2Sel);
      stabNext   = STAB_W'(1);
      if (sameSample) begin
         stabNext = (stabCnt == STAB_MAX) ? stabCnt : stabCnt + STAB_W'(1);
      end
      fire = sameSample && (stabNext == STAB_MAX) && !captured && $onehot(s1Sel);
   end

   // Two-stage input sampling plus the stability bookkeeping. Any change on
   // the bus restarts the dwell and re-arms capture, so each steady period
   // yields exactly one capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Seg    <= '0;
         s2Seg    <= '0;
         s1Sel    <= '0;
         s2Sel    <= '0;
         stabCnt  <= '0;
         captured <= 1'b0;
      end else begin
         s1Seg    <= iSEG;
         s1Sel    <= iDIG_SEL;
         s2Seg    <= s1Seg;
         s2Sel    <= s1Sel;
         stabCnt  <= stabNext;
         captured <= sameSample ? (captured | fire) : 1'b0;
      end
   end

   // Hold the captured pattern and select for one cycle so the decode and
   // per-digit update happen on the following clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         capValid <= 1'b0;
         capSeg   <= '0;
         capSel   <= '0;
      end else begin
         capValid <= fire;
         if (fire) begin
            capSeg <= s1Seg;
            capSel <= s1Sel;
         end
      end
   end

   seg7_inv_lut uLut (
      .seg   (capSeg),
      .legal (lutLegal),
      .hex   (lutHex)
   );

   // Per-digit result registers. A legal pattern replaces the value and marks
   // the digit valid; an illegal one leaves the old value in place and only
   // raises the error flag, so the last good reading is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oDIGITS <= '0;
         oVALID  <= '0;
         oERR    <= '0;
      end else if (capValid) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (capSel[k]) begin
               if (lutLegal) begin
                  oDIGITS[4*k +: 4] <= lutHex;
                  oVALID[k]         <= 1'b1;
                  oERR[k]           <= 1'b0;
               end else begin
                  oERR[k] <= 1'b1;
               end
            end
         end
      end
   end

   // Mask of digits captured so far in the current scan, including the one
   // being applied right now.
   always_comb begin
      seenNext = seen | capSel;
   end

   // Frame tracking: once every digit has been captured, pulse oFRAME for a
   // cycle and start the next scan from an empty mask. The completing capture
   // is deliberately not counted towards the next scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen   <= '0;
         oFRAME <= 1'b0;
      end else begin
         oFRAME <= 1'b0;
         if (capValid) begin
            if (&seenNext) begin
               oFRAME <= 1'b1;
               seen   <= '0;
            end else begin
               seen <= seenNext;
            end
         end
      end
   end

   // Inactivity watchdog: counts cycles since the last applied capture and
   // saturates. The stale flag is registered from the counter, so it drops
   // one cycle after the capture that restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmoCnt <= '0;
         oSTALE <= 1'b0;
      end else begin
         oSTALE <= (tmoCnt >= TMO_MAX);
         if (capValid) begin
            tmoCnt <= '0;
         end else if (tmoCnt != TMO_MAX) begin
            tmoCnt <= tmoCnt + TMO_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder. Directed scenarios followed by a
// random phase; every cycle the outputs are compared with a reference model
// that tracks dwells on the bus and applies captures by the decoder's rules.
module tb_seg7_scan_decoder;

   localparam int ND      = 4;
   localparam int STABLE  = 4;
   localparam int TIMEOUT = 16;

   localparam logic [6:0] REF_PAT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef struct {
      int         due;
      logic [6:0] seg;
      logic [3:0] sel;
   } capT;

   logic          clk;
   logic          rst_n;
   logic [6:0]    segIn;
   logic [ND-1:0] selIn;
   logic [4*ND-1:0] oDIGITS;
   logic [ND-1:0] oVALID;
   logic [ND-1:0] oERR;
   logic          oFRAME;
   logic          oSTALE;

   int checks;
   int errors;
   int edgeNum;
   int frameObserved;

   logic [15:0] expDigits;
   logic [3:0]  expValid;
   logic [3:0]  expErr;
   logic        expFrame;
   logic        expStale;
   logic [3:0]  seenModel;
   int          tmoModel;
   int          dwellLen;
   bit          haveLast;
   logic [6:0]  lastSeg;
   logic [3:0]  lastSel;
   capT         pending [$];

   seg7_scan_decoder #(
      .NUM_DIGITS     (ND),
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .iSEG     (segIn),
      .iDIG_SEL (selIn),
      .oDIGITS  (oDIGITS),
      .oVALID   (oVALID),
      .oERR     (oERR),
      .oFRAME   (oFRAME),
      .oSTALE   (oSTALE)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts the check and reports a failure.
   task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h at edge %0d", tag, observed, expected, edgeNum);
      end
   endtask

   // Compare every output against the model state for this cycle.
   task automatic checkOutput();
      if (oFRAME === 1'b1) frameObserved++;
      checkOne("digits", 32'(oDIGITS), 32'(expDigits));
      checkOne("valid",  32'(oVALID),  32'(expValid));
      checkOne("err",    32'(oERR),    32'(expErr));
      checkOne("frame",  32'(oFRAME),  32'(expFrame));
      checkOne("stale",  32'(oSTALE),  32'(expStale));
   endtask

   task automatic modelReset();
      expDigits = '0;
      expValid  = '0;
      expErr    = '0;
      expFrame  = 1'b0;
      expStale  = 1'b0;
      seenModel = '0;
      tmoModel  = 0;
      dwellLen  = 0;
      haveLast  = 1'b0;
      pending.delete();
   endtask

   // Apply one capture to the model: find the selected digit, look the
   // pattern up in the reference table, and update value/valid/error/frame.
   task automatic modelApply(input logic [6:0] seg, input logic [3:0] sel);
      int  k;
      int  v;
      bit  legal;
      k = 0;
      for (int i = 0; i < ND; i++) if (sel[i]) k = i;
      legal = 1'b0;
      v     = 0;
      for (int i = 0; i < 16; i++) begin
         if (seg == REF_PAT[i]) begin
            legal = 1'b1;
            v     = i;
         end
      end
      if (legal) begin
         expDigits[4*k +: 4] = 4'(v);
         expValid[k]         = 1'b1;
         expErr[k]           = 1'b0;
      end else begin
         expErr[k] = 1'b1;
      end
      seenModel = seenModel | sel;
      if (seenModel == 4'hF) begin
         expFrame  = 1'b1;
         seenModel = '0;
      end
   endtask

   // Advance the model by one clock edge. A value held on the bus for
   // STABLE consecutive edges with a single digit selected is captured and
   // appears on the outputs two edges later (STABLE+2 edges after first drive).
   task automatic modelStep();
      bit  applied;
      capT c;
      applied = 1'b0;
      edgeNum++;
      if (haveLast && segIn == lastSeg && selIn == lastSel) begin
         dwellLen++;
      end else begin
         dwellLen = 1;
         lastSeg  = segIn;
         lastSel  = selIn;
         haveLast = 1'b1;
      end
      if (dwellLen == STABLE && $countones(selIn) == 1) begin
         pending.push_back('{due: edgeNum + 2, seg: segIn, sel: selIn});
      end
      expFrame = 1'b0;
      expStale = (tmoModel >= TIMEOUT);
      if (pending.size() > 0 && pending[0].due == edgeNum) begin
         c = pending.pop_front();
         modelApply(c.seg, c.sel);
         applied = 1'b1;
      end
      if (applied) tmoModel = 0;
      else if (tmoModel < TIMEOUT) tmoModel++;
   endtask

   // Drive one bus value for n clocks, checking the outputs after each edge.
   task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] sel, input int n);
      segIn = seg;
      selIn = sel;
      repeat (n) begin
         @(posedge clk);
         #1;
         modelStep();
         checkOutput();
      end
   endtask

   // Assert reset between edges, check that it clears outputs immediately,
   // keep it for n edges, then release between edges.
   task automatic applyReset(input int n);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput();
      repeat (n) begin
         @(posedge clk);
         #1;
         checkOutput();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      logic [6:0] rSeg;
      logic [3:0] rSel;
      int         pick;
      int         b0;
      int         b1;

      checks        = 0;
      errors        = 0;
      edgeNum       = 0;
      frameObserved = 0;
      rst_n         = 1'b1;
      segIn         = 7'b1111111;
      selIn         = '0;
      modelReset();

      @(posedge clk);
      #1;
      applyReset(2);
      $display("[TB] reset state checked");

      // Test 1: digit 0 shows 2; appears exactly on the sixth edge.
      applyStimulus(7'b0100100, 4'b0001, 6);
      checkOne("t1 digit0", 32'(oDIGITS[3:0]), 32'h2);
      checkOne("t1 valid0", 32'(oVALID[0]), 32'h1);

      // Test 2: full scan 1, A, 7, F with one frame pulse.
      frameObserved = 0;
      applyStimulus(7'b1111001, 4'b0001, 8);
      applyStimulus(7'b0001000, 4'b0010, 8);
      applyStimulus(7'b1111000, 4'b0100, 8);
      applyStimulus(7'b0001110, 4'b1000, 8);
      checkOne("t2 digits", 32'(oDIGITS), 32'hF7A1);
      checkOne("t2 valid", 32'(oVALID), 32'hF);
      checkOne("t2 frames", 32'(frameObserved), 32'd1);

      // Test 3: a value held for only 3 clocks is ignored; the 9 after it lands.
      applyStimulus(7'b0000010, 4'b0010, 3);
      checkOne("t3 no early", 32'(oDIGITS[7:4]), 32'hA);
      applyStimulus(7'b0011000, 4'b0010, 8);
      checkOne("t3 digit1", 32'(oDIGITS[7:4]), 32'h9);

      // Test 4: blank pattern flags error but keeps the old value.
      applyStimulus(7'b0010010, 4'b0001, 8);
      applyStimulus(7'b1111111, 4'b0001, 6);
      checkOne("t4 err0", 32'(oERR[0]), 32'h1);
      checkOne("t4 hold5", 32'(oDIGITS[3:0]), 32'h5);
      applyStimulus(7'b0110000, 4'b0001, 8);
      checkOne("t4 err0 clr", 32'(oERR[0]), 32'h0);
      checkOne("t4 digit3", 32'(oDIGITS[3:0]), 32'h3);

      // Test 5: multi-hot select never captures and lets the watchdog trip.
      frameObserved = 0;
      applyStimulus(7'b0011001, 4'b0011, 20);
      checkOne("t5 frames", 32'(frameObserved), 32'd0);
      checkOne("t5 stale", 32'(oSTALE), 32'h1);
      applyStimulus(7'b0011001, 4'b0100, 8);
      checkOne("t5 digit2", 32'(oDIGITS[11:8]), 32'h4);
      checkOne("t5 stale clr", 32'(oSTALE), 32'h0);

      // Test 6: reset in the middle of a dwell, then a full fresh dwell.
      applyStimulus(7'b0000000, 4'b1000, 4);
      applyReset(3);
      checkOne("t6 valid rst", 32'(oVALID), 32'h0);
      applyStimulus(7'b0000000, 4'b1000, 5);
      checkOne("t6 not yet", 32'(oVALID), 32'h0);
      applyStimulus(7'b0000000, 4'b1000, 3);
      checkOne("t6 valid", 32'(oVALID), 32'h8);
      checkOne("t6 digit3", 32'(oDIGITS[15:12]), 32'h8);

      // Random phase: mixed legal/illegal patterns, all select shapes,
      // dwells both shorter and longer than the stability window.
      $display("[TB] random phase");
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) < 7) rSeg = REF_PAT[$urandom_range(0, 15)];
         else rSeg = 7'($urandom);
         pick = $urandom_range(0, 9);
         if (pick == 0) begin
            rSel = '0;
         end else if (pick == 1) begin
            b0 = $urandom_range(0, 3);
            b1 = (b0 + $urandom_range(1, 3)) % 4;
            rSel = 4'((1 << b0) | (1 << b1));
         end else begin
            rSel = 4'(1 << $urandom_range(0, 3));
         end
         applyStimulus(rSeg, rSel, $urandom_range(1, 10));
      end
      applyStimulus(7'b1111111, 4'b0000, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
